vc_dest_arbiter: RTL and testbench
==================================

VC_DEST_ARBITER -- requirements
Module: vc_dest_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 10, width of the data word; bit DATA_SIZE-1 is the destination bit (0 = D0, 1 = D1).
REQ-002 Parameter TH_SIZE, default 4, width of every almost-full and almost-empty threshold.
REQ-003 clk  in  1  single clock; all flops on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 init  in  1  request to (re)enter configuration; thresholds are latched while in INIT.
REQ-006 af_vc_i, ae_vc_i, af_d_i, ae_d_i  in  TH_SIZE each  threshold values to latch.
REQ-007 af_vc_o, ae_vc_o, af_d_o, ae_d_o  out  TH_SIZE each  registered thresholds driven to the VC and D FIFOs.
REQ-008 vc0_empty, vc1_empty  in  1 each  VC FIFO empty flags.
REQ-009 vc0_data, vc1_data  in  DATA_SIZE each  VC FIFO read data, valid the cycle after a pop.
REQ-010 d0_almost_full, d1_almost_full  in  1 each  destination FIFO almost-full flags.
REQ-011 pop_vc0, pop_vc1  out  1 each  VC FIFO pop strobes.
REQ-012 push_d0, push_d1  out  1 each  destination FIFO push strobes.
REQ-013 data_out  out  DATA_SIZE  word written to the D FIFOs.
REQ-014 state  out  2  current FSM state; idle  out  1  high when state is IDLE and nothing is in flight.
REQ-015 cnt_d0, cnt_d1  out  8 each  count of words pushed per destination.

Function
REQ-016 FSM states: RESET=00, INIT=01, IDLE=10, ACTIVE=11.
REQ-017 RESET goes to INIT on the first clk edge after reset deasserts.
REQ-018 INIT: thresholds are loaded from *_i every cycle and no pops are issued; the FSM goes to IDLE when init=0.
REQ-019 IDLE: init=1 goes to INIT; otherwise, if (!vc0_empty || !vc1_empty) && !d0_almost_full && !d1_almost_full, go to ACTIVE; no pops are issued in IDLE.
REQ-020 ACTIVE: init=1 goes to INIT; when both VCs are empty and no word is in flight, go to IDLE.
REQ-021 Pop enable = state==ACTIVE && !init && !d0_almost_full && !d1_almost_full.
REQ-022 Strict priority: pop_vc0 = enable && !vc0_empty; pop_vc1 = enable && vc0_empty && !vc1_empty; both are never high together.
REQ-023 Pops may issue back-to-back, one per cycle.
REQ-024 A pop in cycle N sets a registered in-flight flag and source select for cycle N+1.
REQ-025 In cycle N+1, data_out = selected vcX_data (combinational), and push_d0 or push_d1 is asserted per the destination bit; latency from pop to push is exactly 1 cycle.
REQ-026 The in-flight word always completes its push, even if init rises or almost_full asserts in cycle N+1.
REQ-027 Only one word is ever outstanding, so almost_full margin ≥1 guarantees space; push is never gated by almost_full.
REQ-028 cnt_dX increments on each push_dX and wraps 255 -> 0.
REQ-029 When no push occurs, data_out = 0.

Reset
REQ-030 While reset=1, all of the following hold: state = RESET, in-flight = 0, pops/pushes = 0, counters = 0, data_out = 0, idle = 0.
REQ-031 Threshold outputs reset to af_vc_o = 6, ae_vc_o = 4, af_d_o = 5, ae_d_o = 3.
REQ-032 Reset asserted mid-transfer discards the in-flight word, with no push in the following cycle.

Structure
REQ-033 A shared package holds the state encoding, the default thresholds (6/4/5/3), DATA_SIZE and TH_SIZE.
REQ-034 One sub-module, arb_threshold_regs, holds the four threshold registers with load = (state==INIT).

Verification
REQ-035 Reset, then init=1 for 2 cycles with af_vc_i = 7, ae_vc_i = 2, af_d_i = 5, ae_d_i = 1, then init=0 -> outputs latch 7/2/5/1; state goes INIT -> IDLE.
REQ-036 VC0 holds 3 words with dest=1 and VC1 is empty -> 3 consecutive pop_vc0, push_d1 one cycle after each pop, cnt_d1 = 3, then back to IDLE.
REQ-037 Both VCs non-empty -> all VC0 words are drained before the first pop_vc1, and pops never overlap.
REQ-038 d0_almost_full rises during a stream -> pops stop the same cycle, the in-flight word is still pushed, and pops resume when the flag falls.
REQ-039 Push 256 words to D0 -> cnt_d0 wraps to 0; reset asserted in the cycle after a pop -> no push is issued and all outputs are at reset values.

Source files
------------

// File: rtl/vc_dest_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : vc_dest_arbiter_pkg
//  Purpose  : Shared definitions for the VC-to-destination arbiter:
//             FSM state encoding, default data/threshold widths and the
//             threshold values driven out of reset.
//  Revision : 1.0  initial release
// ============================================================================
package vc_dest_arbiter_pkg;

  // Default widths. Modules take these as parameter defaults.
  localparam int DATA_SIZE = 10;
  localparam int TH_SIZE   = 4;

  // FSM encoding is visible on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } arb_state_t;

  // Threshold values presented to the FIFOs until INIT loads new ones.
  localparam int DEF_AF_VC = 6;
  localparam int DEF_AE_VC = 4;
  localparam int DEF_AF_D  = 5;
  localparam int DEF_AE_D  = 3;

endpackage : vc_dest_arbiter_pkg
`default_nettype wire

// File: rtl/arb_threshold_regs.sv
`default_nettype none
// ============================================================================
//  Module   : arb_threshold_regs
//  Purpose  : Holds the four almost-full / almost-empty thresholds sent to
//             the VC and destination FIFOs. The registers track their *_i
//             inputs every cycle the arbiter FSM sits in INIT and hold
//             their value in every other state.
//  Ports    : clk, reset          clock, async active-high reset
//             state               arbiter FSM state (load while INIT)
//             af/ae_vc_i, _d_i    threshold values to capture
//             af/ae_vc_o, _d_o    registered thresholds
//  Revision : 1.0  initial release
// ============================================================================
module arb_threshold_regs #(
  parameter int TH_SIZE = vc_dest_arbiter_pkg::TH_SIZE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         state,
  input  logic [TH_SIZE-1:0] af_vc_i,
  input  logic [TH_SIZE-1:0] ae_vc_i,
  input  logic [TH_SIZE-1:0] af_d_i,
  input  logic [TH_SIZE-1:0] ae_d_i,
  output logic [TH_SIZE-1:0] af_vc_o,
  output logic [TH_SIZE-1:0] ae_vc_o,
  output logic [TH_SIZE-1:0] af_d_o,
  output logic [TH_SIZE-1:0] ae_d_o
);
  import vc_dest_arbiter_pkg::*;

  logic load;
  assign load = (state == ST_INIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_vc_o <= TH_SIZE'(DEF_AF_VC);
      ae_vc_o <= TH_SIZE'(DEF_AE_VC);
      af_d_o  <= TH_SIZE'(DEF_AF_D);
      ae_d_o  <= TH_SIZE'(DEF_AE_D);
    end else if (load) begin
      af_vc_o <= af_vc_i;
      ae_vc_o <= ae_vc_i;
      af_d_o  <= af_d_i;
      ae_d_o  <= ae_d_i;
    end
  end

endmodule : arb_threshold_regs
`default_nettype wire

// File: rtl/vc_dest_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vc_dest_arbiter
//  Purpose  : Moves words from two virtual-channel FIFOs (VC0 has strict
//             priority over VC1) into two destination FIFOs selected by the
//             word's MSB. One word moves per cycle: a pop in cycle N is
//             followed by exactly one push in cycle N+1 using the VC read
//             data that appears in that cycle.
//  Ports    : clk, reset               clock, async active-high reset
//             init                     request (re)configuration
//             af/ae_vc_i, af/ae_d_i    thresholds to latch in INIT
//             af/ae_vc_o, af/ae_d_o    registered thresholds
//             vc0/vc1_empty, _data     VC FIFO status and read data
//             d0/d1_almost_full        destination FIFO back-pressure
//             pop_vc0, pop_vc1         VC FIFO pop strobes
//             push_d0, push_d1         destination FIFO push strobes
//             data_out                 word written to the destination FIFOs
//             state, idle              FSM state and quiescent indicator
//             cnt_d0, cnt_d1           wrapping per-destination push counts
//  Revision : 1.0  initial release
// ============================================================================
module vc_dest_arbiter #(
  parameter int DATA_SIZE = vc_dest_arbiter_pkg::DATA_SIZE,
  parameter int TH_SIZE   = vc_dest_arbiter_pkg::TH_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [TH_SIZE-1:0]   af_vc_i,
  input  logic [TH_SIZE-1:0]   ae_vc_i,
  input  logic [TH_SIZE-1:0]   af_d_i,
  input  logic [TH_SIZE-1:0]   ae_d_i,
  output logic [TH_SIZE-1:0]   af_vc_o,
  output logic [TH_SIZE-1:0]   ae_vc_o,
  output logic [TH_SIZE-1:0]   af_d_o,
  output logic [TH_SIZE-1:0]   ae_d_o,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-1:0] data_out,
  output logic [1:0]           state,
  output logic                 idle,
  output logic [7:0]           cnt_d0,
  output logic [7:0]           cnt_d1
);
  import vc_dest_arbiter_pkg::*;

  arb_state_t           state_q;
  logic                 in_flight_q;  // a word was popped last cycle
  logic                 src_sel_q;    // 0: word comes from VC0, 1: from VC1
  logic                 any_req;
  logic                 d_full;
  logic                 pop_en;
  logic                 dest_bit;
  logic [DATA_SIZE-1:0] sel_data;

  // --------------------------------------------------------------------------
  // Threshold registers
  // --------------------------------------------------------------------------
  arb_threshold_regs #(
    .TH_SIZE (TH_SIZE)
  ) u_th_regs (
    .clk     (clk),
    .reset   (reset),
    .state   (state_q),
    .af_vc_i (af_vc_i),
    .ae_vc_i (ae_vc_i),
    .af_d_i  (af_d_i),
    .ae_d_i  (ae_d_i),
    .af_vc_o (af_vc_o),
    .ae_vc_o (ae_vc_o),
    .af_d_o  (af_d_o),
    .ae_d_o  (ae_d_o)
  );

  // --------------------------------------------------------------------------
  // Request / back-pressure summary
  // --------------------------------------------------------------------------
  assign any_req = !vc0_empty || !vc1_empty;
  assign d_full  = d0_almost_full || d1_almost_full;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          if (!init) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)                    state_q <= ST_INIT;
          else if (any_req && !d_full) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // Leave only once the last word has been pushed, so idle never
          // rises while a push is still pending.
          if (init)                                     state_q <= ST_INIT;
          else if (vc0_empty && vc1_empty && !in_flight_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pop arbitration: VC0 strictly first; VC1 only when VC0 has nothing.
  // Pops react to init/almost_full in the same cycle.
  // --------------------------------------------------------------------------
  assign pop_en  = (state_q == ST_ACTIVE) && !init && !d_full;
  assign pop_vc0 = pop_en && !vc0_empty;
  assign pop_vc1 = pop_en &&  vc0_empty && !vc1_empty;

  // --------------------------------------------------------------------------
  // In-flight tracking and push counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_flight_q <= 1'b0;
      src_sel_q   <= 1'b0;
      cnt_d0      <= 8'd0;
      cnt_d1      <= 8'd0;
    end else begin
      in_flight_q <= pop_vc0 || pop_vc1;
      if (pop_vc0 || pop_vc1) src_sel_q <= pop_vc1;
      // 8-bit counters wrap naturally from 255 to 0.
      if (push_d0) cnt_d0 <= cnt_d0 + 8'd1;
      if (push_d1) cnt_d1 <= cnt_d1 + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Push path. The popped word is on vcX_data the cycle after the pop and
  // is forwarded combinationally. The push is not gated by almost_full or
  // init: with at most one word outstanding, the almost-full margin already
  // guarantees room for it.
  // --------------------------------------------------------------------------
  assign sel_data = src_sel_q ? vc1_data : vc0_data;
  assign dest_bit = sel_data[DATA_SIZE-1];
  assign push_d0  = in_flight_q && !dest_bit;
  assign push_d1  = in_flight_q &&  dest_bit;
  assign data_out = in_flight_q ? sel_data : '0;

  // --------------------------------------------------------------------------
  // Status
  // --------------------------------------------------------------------------
  assign state = state_q;
  assign idle  = (state_q == ST_IDLE) && !in_flight_q;

endmodule : vc_dest_arbiter
`default_nettype wire

// File: tb/tb_vc_dest_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vc_dest_arbiter
//  Purpose  : Self-checking bench for vc_dest_arbiter. Behavioural VC FIFO
//             models feed the DUT; expected pushed words are queued when
//             stimulus is issued and a negedge monitor pops and compares
//             them whenever the DUT pushes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vc_dest_arbiter;

  localparam int DW = 10;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [TW-1:0] af_vc_i, ae_vc_i, af_d_i, ae_d_i;
  logic [TW-1:0] af_vc_o, ae_vc_o, af_d_o, ae_d_o;
  logic          vc0_empty, vc1_empty;
  logic [DW-1:0] vc0_data = '0;
  logic [DW-1:0] vc1_data = '0;
  logic          d0_almost_full, d1_almost_full;
  logic          pop_vc0, pop_vc1, push_d0, push_d1;
  logic [DW-1:0] data_out;
  logic [1:0]    state;
  logic          idle;
  logic [7:0]    cnt_d0, cnt_d1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  vc_dest_arbiter #(
    .DATA_SIZE (DW),
    .TH_SIZE   (TW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .af_vc_i        (af_vc_i),
    .ae_vc_i        (ae_vc_i),
    .af_d_i         (af_d_i),
    .ae_d_i         (ae_d_i),
    .af_vc_o        (af_vc_o),
    .ae_vc_o        (ae_vc_o),
    .af_d_o         (af_d_o),
    .ae_d_o         (ae_d_o),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_out       (data_out),
    .state          (state),
    .idle           (idle),
    .cnt_d0         (cnt_d0),
    .cnt_d1         (cnt_d1)
  );

  // --------------------------------------------------------------------------
  // VC FIFO models: write side driven by stimulus, read side by DUT pops.
  // Read data appears the cycle after the pop.
  // --------------------------------------------------------------------------
  logic [DW-1:0] mem0 [0:1023];
  logic [DW-1:0] mem1 [0:1023];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

  assign vc0_empty = (wp0 == rp0);
  assign vc1_empty = (wp1 == rp1);

  always @(posedge clk) begin
    if (pop_vc0 === 1'b1) begin
      vc0_data <= mem0[rp0[9:0]];
      rp0      <= rp0 + 1;
    end
    if (pop_vc1 === 1'b1) begin
      vc1_data <= mem1[rp1[9:0]];
      rp1      <= rp1 + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic load_vc0(input logic [DW-1:0] w);
    mem0[wp0[9:0]] = w;
    wp0 = wp0 + 1;
  endtask

  task automatic load_vc1(input logic [DW-1:0] w);
    mem1[wp1[9:0]] = w;
    wp1 = wp1 + 1;
  endtask

  // Wait (bounded) until the DUT is idle and every expected word was seen.
  task automatic wait_drained(input string name);
    bit done = 0;
    for (int i = 0; i < 2000; i++) begin
      if (idle === 1'b1 && exp_q.size() == 0 && vc0_empty && vc1_empty) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      pend = 1'b0;
    end else begin
      if (pop_vc0 === 1'b1 || pop_vc1 === 1'b1) begin
        check("pop_exclusive", {31'd0, pop_vc0 & pop_vc1}, 32'd0);
        if (pop_vc1 === 1'b1) check("pop_vc1_priority", {31'd0, vc0_empty}, 32'd1);
      end
      if (pend || push_d0 !== 1'b0 || push_d1 !== 1'b0) begin
        check("push_one_cycle_after_pop", {31'd0, push_d0 | push_d1}, {31'd0, pend});
      end
      if (push_d0 === 1'b1 || push_d1 === 1'b1) begin
        check("push_exclusive", {31'd0, push_d0 & push_d1}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_push", {22'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          check("push_data", {22'd0, data_out}, {22'd0, e});
          check("push_dest", {30'd0, push_d1, push_d0}, {30'd0, e[DW-1], ~e[DW-1]});
        end
      end
      pend = pop_vc0 | pop_vc1;
    end
  end

  // Reset-state snapshot used both at start-up and after mid-transfer reset.
  task automatic check_reset_state(input string tag);
    check({tag, "_state"},   {30'd0, state}, 32'd0);
    check({tag, "_pops"},    {30'd0, pop_vc0, pop_vc1}, 32'd0);
    check({tag, "_pushes"},  {30'd0, push_d0, push_d1}, 32'd0);
    check({tag, "_cnts"},    {16'd0, cnt_d0, cnt_d1}, 32'd0);
    check({tag, "_data"},    {22'd0, data_out}, 32'd0);
    check({tag, "_idle"},    {31'd0, idle}, 32'd0);
    check({tag, "_thresh"},  {16'd0, af_vc_o, ae_vc_o, af_d_o, ae_d_o}, 32'h6453);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset = 1'b1; init = 1'b1;
    af_vc_i = 4'd7; ae_vc_i = 4'd2; af_d_i = 4'd5; ae_d_i = 4'd1;
    d0_almost_full = 1'b0; d1_almost_full = 1'b0;

    // ---- Reset and configuration ----
    repeat (2) @(posedge clk); #1;
    check_reset_state("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    check("state_init", {30'd0, state}, 32'd1);
    @(posedge clk); #1;
    check("state_init_hold", {30'd0, state}, 32'd1);
    init = 1'b0;
    @(posedge clk); #1;
    check("state_idle", {30'd0, state}, 32'd2);
    check("idle_flag", {31'd0, idle}, 32'd1);
    check("thresholds_latched", {16'd0, af_vc_o, ae_vc_o, af_d_o, ae_d_o}, 32'h7251);

    // ---- VC0 only, three words to D1 ----
    load_vc0(10'h201); load_vc0(10'h202); load_vc0(10'h203);
    exp_q.push_back(10'h201); exp_q.push_back(10'h202); exp_q.push_back(10'h203);
    @(posedge clk); #1;
    check("state_active", {30'd0, state}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("vc0_back_to_back_pop", {31'd0, pop_vc0}, 32'd1);
      @(posedge clk); #1;
    end
    check("no_pop_after_drain", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    wait_drained("drain_vc0_only");
    check("cnt_after_vc0", {16'd0, cnt_d0, cnt_d1}, {16'd0, 8'd0, 8'd3});
    check("back_to_idle", {30'd0, state}, 32'd2);

    // ---- Both VCs: VC0 words must all precede VC1 ----
    load_vc1(10'h211); load_vc1(10'h212);
    load_vc0(10'h021); load_vc0(10'h022);
    exp_q.push_back(10'h021); exp_q.push_back(10'h022);
    exp_q.push_back(10'h211); exp_q.push_back(10'h212);
    wait_drained("drain_both_vcs");
    check("cnt_after_both", {16'd0, cnt_d0, cnt_d1}, {16'd0, 8'd2, 8'd5});

    // ---- almost_full back-pressure mid-stream ----
    for (int i = 1; i <= 6; i++) begin
      load_vc0(DW'(10'h030 + i));
      exp_q.push_back(DW'(10'h030 + i));
    end
    @(posedge clk); #1;                   // ACTIVE, first pop
    check("af_first_pop", {31'd0, pop_vc0}, 32'd1);
    @(posedge clk); #1;                   // first word in flight
    d0_almost_full = 1'b1;
    #1;
    check("af_pop_stops", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    check("af_inflight_pushed", {31'd0, push_d0}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("af_pop_held", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    end
    d0_almost_full = 1'b0;
    #1;
    check("af_pop_resumes", {31'd0, pop_vc0}, 32'd1);
    wait_drained("drain_after_af");
    check("cnt_after_af", {16'd0, cnt_d0, cnt_d1}, {16'd0, 8'd8, 8'd5});

    // ---- counter wrap: 248 more words to D0 makes 256 ----
    for (int i = 0; i < 248; i++) begin
      load_vc0(DW'(i));
      exp_q.push_back(DW'(i));
    end
    wait_drained("drain_wrap");
    check("cnt_d0_wrap", {16'd0, cnt_d0, cnt_d1}, {16'd0, 8'd0, 8'd5});

    // ---- reset in the cycle after a pop discards the word ----
    begin
      bit seen = 0;
      load_vc0(10'h2AA);                  // intentionally not expected
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (pop_vc0 === 1'b1) begin
          seen = 1;
          break;
        end
      end
      check("reset_test_pop_seen", {31'd0, seen}, 32'd1);
      @(posedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("midreset");
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
    end

    repeat (3) @(posedge clk); #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_vc_dest_arbiter
`default_nettype wire
